// File: rtl/nrzi_stuff_enc_if.sv
// Word handshake and line-side signals of the NRZI bit-stuffing encoder.
// The master drives words; the slave (encoder) drives the line.
interface nrzi_stuff_enc_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              last_i;
  logic              ready_o;
  logic              y_o;
  logic              oe_o;
  logic              busy_o;
  logic              err_o;

  modport master (
    output data_i, valid_i, last_i,
    input  ready_o, y_o, oe_o, busy_o, err_o
  );

  modport slave (
    input  data_i, valid_i, last_i,
    output ready_o, y_o, oe_o, busy_o, err_o
  );
endinterface

// File: rtl/nrzi_stuff_enc.sv
// Serialises words LSB first onto an NRZI line with optional USB-style
// bit stuffing, enabled by defining NRZI_STUFF_EN.
module nrzi_stuff_enc #(
  parameter int   DATA_W     = 8,
  parameter int   STUFF_RUN  = 6,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  nrzi_stuff_enc_if.slave bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STUFF
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              lastf, lastf_n;
  logic              y, y_n;
  logic              oe, oe_n;
  logic              err, err_n;

  logic word_end;
  logic fin;
  logic ready;
  logic load;
  logic adv;
  logic go_idle;
  logic stuff_go;
  logic stuff_pend;

`ifdef NRZI_STUFF_EN
  localparam int RW = $clog2(STUFF_RUN + 1);

  logic [RW-1:0] run, run_n;

  // run counts 1s on the line including the bit currently shown
  assign stuff_pend = (state == SHIFT) && (run == RW'(STUFF_RUN));

  always_comb begin
    run_n = run;
    if (go_idle || stuff_go) begin
      run_n = '0;
    end else if (adv) begin
      run_n = sh[0] ? run + 1'b1 : '0;
    end else if (load) begin
      run_n = bus.data_i[0] ? run + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      run <= '0;
    end else begin
      run <= run_n;
    end
  end
`else
  assign stuff_pend = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_n     = sh;
    lastf_n  = lastf;
    y_n      = y;
    oe_n     = oe;
    err_n    = 1'b0;
    word_end = (cnt == LAST_IDX);
    fin      = 1'b0;
    adv      = 1'b0;
    stuff_go = 1'b0;

    unique case (state)
      IDLE: ;
      SHIFT: begin
        fin      = word_end && !stuff_pend;
        stuff_go = stuff_pend;
        adv      = !word_end && !stuff_pend;
      end
      STUFF: begin
        fin = word_end;
        adv = !word_end;
      end
      default: ;
    endcase

    ready   = (state == IDLE) || (fin && !lastf);
    load    = bus.valid_i && ready;
    go_idle = fin && !load;

    if (stuff_go) begin
      state_n = STUFF;
      y_n     = ~y;
    end
    if (adv) begin
      state_n = SHIFT;
      cnt_n   = cnt + 1'b1;
      y_n     = sh[0] ? y : ~y;
      sh_n    = sh >> 1;
    end
    if (go_idle) begin
      state_n = IDLE;
      cnt_n   = '0;
      sh_n    = '0;
      lastf_n = 1'b0;
      y_n     = IDLE_LEVEL;
      oe_n    = 1'b0;
      err_n   = !lastf;
    end
    // a new word continues the line level gaplessly
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sh_n    = bus.data_i >> 1;
      lastf_n = bus.last_i;
      y_n     = bus.data_i[0] ? y : ~y;
      oe_n    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      lastf <= 1'b0;
      y     <= IDLE_LEVEL;
      oe    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      lastf <= lastf_n;
      y     <= y_n;
      oe    <= oe_n;
      err   <= err_n;
    end
  end

  assign bus.ready_o = ready;
  assign bus.y_o     = y;
  assign bus.oe_o    = oe;
  assign bus.err_o   = err;
  assign bus.busy_o  = (state != IDLE);

endmodule

// File: tb/tb_nrzi_stuff_enc.sv
// Bench for nrzi_stuff_enc: frame table driven through a line-level
// reference stream, plus reset and idle corner sequences.
module tb_nrzi_stuff_enc;

  localparam int DW  = 8;
  localparam int RUN = 6;
`ifdef NRZI_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nrzi_stuff_enc_if #(.DATA_W(DW)) bus ();

  nrzi_stuff_enc #(
    .DATA_W(DW),
    .STUFF_RUN(RUN),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk_i(clk),
    .resetn_i(rst_n),
    .bus(bus)
  );

  typedef struct {
    int              n;
    logic [3:0][7:0] w;
    bit              underrun;
    int              oe_stuff;
    int              oe_plain;
  } vec_t;

  typedef struct packed {
    logic y;
    logic oe;
    logic busy;
    logic ready;
    logic err;
  } obs_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  vec_t post;
  obs_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(logic y, logic oe, logic busy,
                              logic ready, logic err);
    return {y, oe, busy, ready, err};
  endfunction

  function automatic obs_t obs();
    return {bus.y_o, bus.oe_o, bus.busy_o, bus.ready_o, bus.err_o};
  endfunction

  task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05b expected %05b (y oe busy ready err)",
               nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Line-level model: bit list, stuff insertion, then NRZI
  function automatic void build(input vec_t v);
    logic y = 1'b1;
    int   run = 0;
    bit   lw, b, st;
    for (int w = 0; w < v.n; w++) begin
      lw = (w == v.n - 1) && !v.underrun;
      for (int i = 0; i < DW; i++) begin
        b = v.w[w][i];
        if (!b) y = ~y;
        run = b ? run + 1 : 0;
        st = STUFF_ON && (run == RUN);
        exp_q.push_back(mk(y, 1'b1, 1'b1, (i == DW - 1) && !st && !lw, 1'b0));
        if (st) begin
          y = ~y;
          run = 0;
          exp_q.push_back(mk(y, 1'b1, 1'b1, (i == DW - 1) && !lw, 1'b0));
        end
      end
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, v.underrun));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int   k = 0;
    int   cyc = 0;
    int   oe_cnt = 0;
    int   budget;
    bit   started = 1'b0;
    bit   acc;
    obs_t e;
    obs_t a;
    build(v);
    budget = exp_q.size() + 20;
    @(negedge clk);
    bus.data_i  = v.w[0];
    bus.last_i  = (v.n == 1) && !v.underrun;
    bus.valid_i = 1'b1;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (started) begin
        e = exp_q.pop_front();
        a = obs();
        chk_obs($sformatf("vec%0d cyc%0d", id, cyc), a, e);
        if (a.oe) oe_cnt++;
      end
      acc = bus.valid_i && bus.ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        started = 1'b1;
        k++;
        if (k < v.n) begin
          bus.data_i = v.w[k];
          bus.last_i = (k == v.n - 1) && !v.underrun;
        end else begin
          bus.valid_i = 1'b0;
          bus.data_i  = 8'($urandom);
          bus.last_i  = 1'($urandom);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk_int($sformatf("vec%0d timeout_left", id), exp_q.size(), 0);
      exp_q.delete();
      bus.valid_i = 1'b0;
    end
    chk_int($sformatf("vec%0d oe_cycles", id), oe_cnt,
            STUFF_ON ? v.oe_stuff : v.oe_plain);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.last_i  = 1'b0;

    vecs[0] = '{n: 1, w: 32'h0000_0000, underrun: 0, oe_stuff: 8,  oe_plain: 8};
    vecs[1] = '{n: 1, w: 32'h0000_00FF, underrun: 0, oe_stuff: 9,  oe_plain: 8};
    vecs[2] = '{n: 2, w: 32'h0000_013F, underrun: 0, oe_stuff: 17, oe_plain: 16};
    vecs[3] = '{n: 1, w: 32'h0000_00A5, underrun: 1, oe_stuff: 8,  oe_plain: 8};
    vecs[4] = '{n: 2, w: 32'h0000_FF80, underrun: 0, oe_stuff: 17, oe_plain: 16};
    vecs[5] = '{n: 3, w: 32'h000F_AA55, underrun: 0, oe_stuff: 24, oe_plain: 24};
    vecs[6] = '{n: 4, w: 32'hFFFF_FFFF, underrun: 0, oe_stuff: 37, oe_plain: 32};
    post    = '{n: 1, w: 32'h0000_003F, underrun: 0, oe_stuff: 9,  oe_plain: 8};

    #12;
    chk_obs("reset_state", obs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // abort a word of ones during bit 3
    @(negedge clk);
    bus.data_i  = 8'hFF;
    bus.last_i  = 1'b0;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_obs("bit3_before_reset", obs(), mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    chk_obs("async_reset", obs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    chk_obs("reset_hold", obs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk_obs("after_reset_no_err", obs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    run_vec(post, NV);

    // junk on data/last while idle with valid low
    repeat (3) begin
      bus.data_i = 8'($urandom);
      bus.last_i = 1'($urandom);
      @(negedge clk);
      chk_obs("idle_junk", obs(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
